// File: rtl/operand_fetch_sequencer.sv
// Operand fetch sequencer: owns a single-port register file, fetches up to two
// source operands per instruction and hands them to the ALU stage. Writeback
// always wins the port; blocked reads retry and are counted in stallCount.
module operand_fetch_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int ZERO_REG        = 31,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issueValid,
    output logic                       issueReady,
    input  logic [4:0]                 issueReg1,
    input  logic [4:0]                 issueReg2,
    input  logic                       issueAluSRC,
    input  logic [DATA_WIDTH-1:0]      issueOffset,
    input  logic                       wbValid,
    input  logic [4:0]                 wbReg,
    input  logic [DATA_WIDTH-1:0]      wbData,
    output logic [4:0]                 rfAddr,
    output logic                       rfWriteEn,
    output logic [DATA_WIDTH-1:0]      rfWriteData,
    input  logic [DATA_WIDTH-1:0]      rfReadData,
    output logic                       opValid,
    input  logic                       opReady,
    output logic [DATA_WIDTH-1:0]      readData1,
    output logic [DATA_WIDTH-1:0]      readData2,
    output logic [DATA_WIDTH-1:0]      pcOffsetFilled,
    output logic [STALL_CNT_WIDTH-1:0] stallCount
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    typedef enum logic [1:0] {IDLE, RD1, RD2, OUT} state_t;

    state_t                     r_state, w_next;
    logic [4:0]                 r_reg1, r_reg2;
    logic                       r_alusrc;
    logic [DATA_WIDTH-1:0]      r_offset, r_rd1, r_rd2;
    logic [STALL_CNT_WIDTH-1:0] r_stall;

    logic       w_wr, w_reading, w_rd_zero, w_stall, w_capture;
    logic [4:0] w_rd_sel;

    // A write needs the port unless it targets the zero register; reset
    // suppresses it so nothing reaches the RF in a reset cycle.
    assign w_wr      = reset && wbValid && (wbReg != ZR);
    assign w_reading = (r_state == RD1) || (r_state == RD2);
    assign w_rd_sel  = (r_state == RD2) ? r_reg2 : r_reg1;
    // Zero-register reads never touch the port, so they cannot be blocked.
    assign w_rd_zero = (w_rd_sel == ZR);
    assign w_stall   = w_reading && w_wr && !w_rd_zero;
    assign w_capture = w_reading && !w_stall;

    assign readData1      = r_rd1;
    assign readData2      = r_rd2;
    assign pcOffsetFilled = r_offset;
    assign stallCount     = r_stall;

    // Next state, handshake signals and port arbitration (writeback first).
    always_comb begin
        w_next      = r_state;
        issueReady  = 1'b0;
        opValid     = 1'b0;
        rfWriteEn   = 1'b0;
        rfAddr      = '0;
        rfWriteData = '0;
        if (reset) begin
            if (w_wr) begin
                rfWriteEn   = 1'b1;
                rfAddr      = wbReg;
                rfWriteData = wbData;
            end else if (w_reading && !w_rd_zero) begin
                rfAddr = w_rd_sel;
            end
            case (r_state)
                IDLE: begin
                    issueReady = 1'b1;
                    if (issueValid) w_next = RD1;
                end
                RD1: if (w_capture) w_next = r_alusrc ? OUT : RD2;
                RD2: if (w_capture) w_next = OUT;
                OUT: begin
                    opValid = 1'b1;
                    if (opReady) w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // State, latched instruction fields, operand capture/bypass and stall counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_reg1   <= '0;
            r_reg2   <= '0;
            r_alusrc <= 1'b0;
            r_offset <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_stall  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && issueValid) begin
                r_reg1   <= issueReg1;
                r_reg2   <= issueReg2;
                r_alusrc <= issueAluSRC;
                r_offset <= issueOffset;
            end
            if (w_stall && (r_stall != {STALL_CNT_WIDTH{1'b1}}))
                r_stall <= r_stall + 1'b1;
            // Operand 1: capture in RD1, then track writes to its register.
            if (r_state == RD1 && w_capture)
                r_rd1 <= w_rd_zero ? '0 : rfReadData;
            else if ((r_state == RD2 || r_state == OUT) && w_wr && wbReg == r_reg1)
                r_rd1 <= wbData;
            // Operand 2: offset or register; only a register operand is bypassed.
            if (r_state == RD1 && w_capture && r_alusrc)
                r_rd2 <= r_offset;
            else if (r_state == RD2 && w_capture)
                r_rd2 <= w_rd_zero ? '0 : rfReadData;
            else if (r_state == OUT && !r_alusrc && w_wr && wbReg == r_reg2)
                r_rd2 <= wbData;
        end
    end

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Bench for operand_fetch_sequencer: directed scenarios plus randomized
// instructions with random writeback traffic, checked against an
// architectural register model (operands must equal the current register
// contents at the ALU handshake).
module tb_operand_fetch_sequencer;

    logic        clock, reset;
    logic        issueValid, issueReady, issueAluSRC;
    logic [4:0]  issueReg1, issueReg2, wbReg, rfAddr;
    logic [31:0] issueOffset, wbData, rfWriteData, rfReadData;
    logic        wbValid, rfWriteEn, opValid, opReady;
    logic [31:0] readData1, readData2, pcOffsetFilled;
    logic [15:0] stallCount;

    logic [31:0] rf_mem [32];
    logic [31:0] mdl    [32];
    int          checks = 0, errors = 0;
    int          wrcnt = 0, reg9_reads = 0;

    operand_fetch_sequencer dut (
        .clock(clock), .reset(reset),
        .issueValid(issueValid), .issueReady(issueReady),
        .issueReg1(issueReg1), .issueReg2(issueReg2),
        .issueAluSRC(issueAluSRC), .issueOffset(issueOffset),
        .wbValid(wbValid), .wbReg(wbReg), .wbData(wbData),
        .rfAddr(rfAddr), .rfWriteEn(rfWriteEn), .rfWriteData(rfWriteData),
        .rfReadData(rfReadData),
        .opValid(opValid), .opReady(opReady),
        .readData1(readData1), .readData2(readData2),
        .pcOffsetFilled(pcOffsetFilled), .stallCount(stallCount)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Register file behind the port: combinational read, clocked write.
    assign rfReadData = rf_mem[rfAddr];
    always @(posedge clock) if (rfWriteEn) rf_mem[rfAddr] <= rfWriteData;

    // Port activity monitor.
    always @(negedge clock) begin
        if (rfWriteEn) wrcnt++;
        if (!rfWriteEn && rfAddr == 5'd9) reg9_reads++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; the model applies any architectural write seen at it.
    task automatic tick();
        @(posedge clock);
        if (reset && wbValid && wbReg != 5'd31) mdl[wbReg] = wbData;
        #1;
    endtask

    function automatic logic [31:0] regval(input logic [4:0] r);
        return (r == 5'd31) ? 32'h0 : mdl[r];
    endfunction

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic src,
                         input logic [31:0] off);
        issueValid = 1'b1; issueReg1 = r1; issueReg2 = r2;
        issueAluSRC = src; issueOffset = off;
        #2;
        check("issueReady_at_issue", {31'b0, issueReady}, 32'd1);
        tick();
        issueValid = 1'b0;
    endtask

    // Wait for opValid; lat counts cycles after the handshake edge.
    task automatic wait_op(input int start, output int lat);
        lat = start;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (opValid) break;
            tick();
            lat++;
        end
        if (!opValid) check("opValid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, w0, r9, nbad, n;
        logic [4:0]  r1, r2;
        logic        src, done;
        logic [31:0] off;

        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        reset = 1'b0; issueValid = 1'b0; issueReg1 = '0; issueReg2 = '0;
        issueAluSRC = 1'b0; issueOffset = '0; opReady = 1'b1;
        // A writeback during reset must not reach the register file.
        wbValid = 1'b1; wbReg = 5'd3; wbData = 32'hDEAD_BEEF;
        tick(); tick();
        #2;
        check("rst_issueReady", {31'b0, issueReady}, 32'd0);
        check("rst_opValid",    {31'b0, opValid},    32'd0);
        check("rst_rfWriteEn",  {31'b0, rfWriteEn},  32'd0);
        check("rst_stallCount", {16'b0, stallCount}, 32'd0);
        check("rst_readData1",  readData1,           32'd0);
        check("rst_pcOffset",   pcOffsetFilled,      32'd0);
        check("rst_no_write",   {31'b0, rf_mem[3] === 32'hDEAD_BEEF}, 32'd0);
        reset = 1'b1; wbValid = 1'b0;
        #1;
        check("issueReady_after_reset", {31'b0, issueReady}, 32'd1);

        // Preload registers 0..30 through the writeback port.
        for (int i = 0; i < 31; i++) begin
            wbValid = 1'b1; wbReg = 5'(i);
            wbData = (i == 3) ? 32'h11 : (i == 5) ? 32'h22 : $urandom;
            tick();
        end
        wbValid = 1'b0;

        // Two register operands.
        issue(5'd3, 5'd5, 1'b0, 32'h0);
        wait_op(1, lat);
        check("t1_latency", lat, 32'd3);
        check("t1_rd1", readData1, 32'h11);
        check("t1_rd2", readData2, 32'h22);
        tick(); #2;
        check("t1_back_idle", {31'b0, issueReady}, 32'd1);

        // Immediate operand: reg2 must never be read.
        r9 = reg9_reads;
        issue(5'd4, 5'd9, 1'b1, 32'h40);
        wait_op(1, lat);
        check("t2_latency", lat, 32'd2);
        check("t2_rd1", readData1, regval(5'd4));
        check("t2_rd2", readData2, 32'h40);
        check("t2_pcoff", pcOffsetFilled, 32'h40);
        check("t2_no_reg2_read", reg9_reads - r9, 32'd0);
        tick();

        // Three back-to-back writebacks stall RD1.
        w0 = wrcnt;
        issue(5'd10, 5'd11, 1'b0, 32'h0);
        for (int i = 7; i <= 9; i++) begin
            wbValid = 1'b1; wbReg = 5'(i); wbData = 32'hA000 + 32'(i);
            tick();
        end
        wbValid = 1'b0;
        wait_op(4, lat);
        check("t3_latency", lat, 32'd6);
        check("t3_stalls", {16'b0, stallCount}, 32'd3);
        check("t3_writes", wrcnt - w0, 32'd3);
        check("t3_rf8", rf_mem[8], 32'hA008);
        check("t3_rd1", readData1, regval(5'd10));
        check("t3_rd2", readData2, regval(5'd11));
        tick();

        // Write to the register being read, then bypass while in OUT.
        opReady = 1'b0;
        issue(5'd6, 5'd12, 1'b0, 32'h0);
        wbValid = 1'b1; wbReg = 5'd6; wbData = 32'hABCD;
        tick();
        wbValid = 1'b0;
        wait_op(2, lat);
        check("t4_latency", lat, 32'd4);
        check("t4_rd1_new", readData1, 32'hABCD);
        wbValid = 1'b1; wbReg = 5'd6; wbData = 32'h1234;
        tick();
        wbValid = 1'b0;
        #2;
        check("t4_opValid_held", {31'b0, opValid}, 32'd1);
        check("t4_rd1_bypass", readData1, 32'h1234);
        check("t4_rd2", readData2, regval(5'd12));
        opReady = 1'b1;
        tick();

        // Zero-register operands with a concurrent unrelated write.
        issue(5'd31, 5'd31, 1'b0, 32'h0);
        wbValid = 1'b1; wbReg = 5'd2; wbData = 32'h5555;
        tick();
        wbValid = 1'b0;
        wait_op(2, lat);
        check("t5_latency", lat, 32'd3);
        check("t5_rd1", readData1, 32'h0);
        check("t5_rd2", readData2, 32'h0);
        check("t5_stalls", {16'b0, stallCount}, 32'd4);
        check("t5_rf2", rf_mem[2], 32'h5555);
        tick();
        w0 = wrcnt;
        wbValid = 1'b1; wbReg = 5'd31; wbData = 32'hFFFF;
        #1;
        check("t5_zr_no_wen", {31'b0, rfWriteEn}, 32'd0);
        tick();
        wbValid = 1'b0;
        check("t5_zr_no_write", wrcnt - w0, 32'd0);

        // Reset in the middle of RD2.
        issue(5'd3, 5'd5, 1'b0, 32'h77);
        tick();
        reset = 1'b0;
        tick(); #2;
        check("t6_opValid", {31'b0, opValid}, 32'd0);
        check("t6_issueReady", {31'b0, issueReady}, 32'd0);
        check("t6_stalls", {16'b0, stallCount}, 32'd0);
        check("t6_rd1", readData1, 32'd0);
        check("t6_pcoff", pcOffsetFilled, 32'd0);
        reset = 1'b1;
        issue(5'd13, 5'd14, 1'b0, 32'h99);
        wait_op(1, lat);
        check("t6_latency", lat, 32'd3);
        check("t6_rd1", readData1, regval(5'd13));
        check("t6_rd2", readData2, regval(5'd14));
        tick();

        // Randomized instructions under random writeback traffic.
        for (int t = 0; t < 30; t++) begin
            r1  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            src = 1'($urandom_range(0, 1));
            off = $urandom;
            wbValid = ($urandom_range(0, 2) == 0); wbReg = 5'($urandom_range(0, 31));
            wbData = $urandom;
            issue(r1, r2, src, off);
            done = 1'b0;
            n = 0;
            while (!done && n < 60) begin
                wbValid = ($urandom_range(0, 2) == 0);
                wbReg   = 5'($urandom_range(0, 31));
                wbData  = $urandom;
                opReady = 1'($urandom_range(0, 1));
                #2;
                if (opValid) begin
                    check("rnd_no_overlap", {31'b0, issueReady}, 32'd0);
                    if (opReady) begin
                        check("rnd_rd1", readData1, regval(r1));
                        check("rnd_rd2", readData2, src ? off : regval(r2));
                        check("rnd_pcoff", pcOffsetFilled, off);
                        done = 1'b1;
                    end
                end
                tick();
                n++;
            end
            if (!done) check("rnd_timeout", 32'd0, 32'd1);
            wbValid = 1'b0; opReady = 1'b1;
        end

        nbad = 0;
        for (int i = 0; i < 31; i++) if (rf_mem[i] !== mdl[i]) nbad++;
        check("rf_consistency", nbad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
